// File: rtl/vadd_seq_ctrl.sv
// Sequencer for z[i] = a * x[i] + y[i] over a vector of len elements, with valid/ready streams.
// Define VADD_CTRL_SAT_EN to saturate results at 255 instead of wrapping modulo 256.
module vadd_seq_ctrl #(
   parameter int unsigned LEN_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [7:0]       a_d,
   input  logic             a_v,
   output logic             a_r,
   input  logic [7:0]       x_d,
   input  logic             x_v,
   output logic             x_r,
   input  logic [7:0]       y_d,
   input  logic             y_v,
   output logic             y_r,
   output logic [7:0]       z_d,
   output logic             z_v,
   input  logic             z_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StStream,
      StDrain,
      StFinish
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [7:0]       a_reg_q, a_reg_d;
   logic [7:0]       zdata_q, zdata_d;
   logic             zvld_q, zvld_d;
   logic             fire;
   logic [7:0]       result;

`ifdef VADD_CTRL_SAT_EN
   logic [16:0] mac;
   always_comb begin
      mac    = 17'(a_reg_q * x_d) + 17'(y_d);
      result = (mac > 17'd255) ? 8'hFF : mac[7:0];
   end
`else
   always_comb begin
      result = a_reg_q * x_d + y_d;
   end
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      a_reg_d = a_reg_q;
      zdata_d = zdata_q;
      zvld_d  = zvld_q;
      a_r     = 1'b0;
      x_r     = 1'b0;
      y_r     = 1'b0;
      fire    = 1'b0;

      // Accepted output clears valid; a same-cycle fire below re-asserts it.
      if (zvld_q && z_r) begin
         zvld_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               rem_d   = len;
               state_d = (len == '0) ? StFinish : StLoadA;
            end
         end
         StLoadA: begin
            a_r = 1'b1;
            if (a_v) begin
               a_reg_d = a_d;
               state_d = StStream;
            end
         end
         StStream: begin
            fire = x_v && y_v && (!zvld_q || z_r);
            x_r  = fire;
            y_r  = fire;
            if (fire) begin
               zdata_d = result;
               zvld_d  = 1'b1;
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (zvld_q && z_r) begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         rem_q   <= '0;
         a_reg_q <= '0;
         zdata_q <= '0;
         zvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         a_reg_q <= a_reg_d;
         zdata_q <= zdata_d;
         zvld_q  <= zvld_d;
      end
   end

   assign z_d  = zdata_q;
   assign z_v  = zvld_q;
   assign busy = (state_q != StIdle);
   assign done = (state_q == StFinish);

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
// Directed self-checking bench for vadd_seq_ctrl; inputs change on the falling edge,
// outputs are sampled shortly after it.
module tb_vadd_seq_ctrl;

   localparam int unsigned LEN_W = 16;
`ifdef VADD_CTRL_SAT_EN
   localparam logic [7:0] ArithExp = 8'd255;
`else
   localparam logic [7:0] ArithExp = 8'd149;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [LEN_W-1:0] len;
   logic [7:0]       a_d, x_d, y_d, z_d;
   logic             a_v, a_r, x_v, x_r, y_v, y_r, z_v, z_r;
   logic             busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   vadd_seq_ctrl #(.LEN_W(LEN_W)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .len   (len),
      .a_d   (a_d),
      .a_v   (a_v),
      .a_r   (a_r),
      .x_d   (x_d),
      .x_v   (x_v),
      .x_r   (x_r),
      .y_d   (y_d),
      .y_v   (y_v),
      .y_r   (y_r),
      .z_d   (z_d),
      .z_v   (z_v),
      .z_r   (z_r),
      .busy  (busy),
      .done  (done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Start an operation and load the scalar; returns at a falling edge in the stream state.
   task automatic start_op(input logic [LEN_W-1:0] l, input logic [7:0] a);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      a_d   = a;
      a_v   = 1'b1;
      tick();
      a_v   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0; len = '0;
      a_d = '0; a_v = 1'b0; x_d = '0; x_v = 1'b0; y_d = '0; y_v = 1'b0; z_r = 1'b0;
      tick();
      n_checks++;
      if ({busy, done, a_r, x_r, y_r, z_v} !== 6'b0)
         $display("FAIL reset_ctrl: got %b want %b", {busy, done, a_r, x_r, y_r, z_v}, 6'b0);
      else n_pass++;
      n_checks++;
      if (z_d !== 8'd0) $display("FAIL reset_zd: got %0d want 0", z_d);
      else n_pass++;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] xs  [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
      logic [7:0] exps[4] = '{8'd13, 8'd16, 8'd19, 8'd22};
      start = 1'b1; len = 16'd4;
      tick();
      start = 1'b0; len = 16'hFFFF; a_d = 8'd3; a_v = 1'b1;
      #1;
      n_checks++;
      if ({a_r, busy} !== 2'b11) $display("FAIL basic_load: got %b want 11", {a_r, busy});
      else n_pass++;
      tick();
      a_v = 1'b0; a_d = 8'd99; x_v = 1'b1; y_v = 1'b1; z_r = 1'b1;
      for (int i = 0; i < 4; i++) begin
         x_d = xs[i]; y_d = 8'd10;
         #1;
         n_checks++;
         if ({x_r, y_r} !== 2'b11) $display("FAIL basic_fire%0d: got %b want 11", i, {x_r, y_r});
         else n_pass++;
         tick();
         n_checks++;
         if ({z_v, z_d} !== {1'b1, exps[i]})
            $display("FAIL basic_z%0d: got v=%b d=%0d want v=1 d=%0d", i, z_v, z_d, exps[i]);
         else n_pass++;
      end
      #1;
      n_checks++;
      if ({a_r, x_r, y_r, busy, done} !== 5'b00010)
         $display("FAIL basic_drain: got %b want 00010", {a_r, x_r, y_r, busy, done});
      else n_pass++;
      x_v = 1'b0; y_v = 1'b0;
      tick();
      n_checks++;
      if ({done, z_v} !== 2'b10) $display("FAIL basic_done: got %b want 10", {done, z_v});
      else n_pass++;
      tick();
      n_checks++;
      if ({done, busy} !== 2'b00) $display("FAIL basic_idle: got %b want 00", {done, busy});
      else n_pass++;
   endtask

   task automatic test_len0();
      start = 1'b1; len = '0; a_v = 1'b1; x_v = 1'b1; y_v = 1'b1; z_r = 1'b1;
      #1;
      n_checks++;
      if ({a_r, x_r, y_r, busy, done} !== 5'b0)
         $display("FAIL len0_idle: got %b want 00000", {a_r, x_r, y_r, busy, done});
      else n_pass++;
      tick();
      start = 1'b0;
      #1;
      n_checks++;
      if ({a_r, x_r, y_r, busy, done} !== 5'b00011)
         $display("FAIL len0_finish: got %b want 00011", {a_r, x_r, y_r, busy, done});
      else n_pass++;
      tick();
      n_checks++;
      if ({a_r, x_r, y_r, busy, done, z_v} !== 6'b0)
         $display("FAIL len0_after: got %b want 000000", {a_r, x_r, y_r, busy, done, z_v});
      else n_pass++;
      a_v = 1'b0; x_v = 1'b0; y_v = 1'b0;
   endtask

   task automatic test_arith();
      start_op(16'd1, 8'd20);
      x_v = 1'b1; y_v = 1'b1; x_d = 8'd20; y_d = 8'd5; z_r = 1'b1;
      tick();
      n_checks++;
      if ({z_v, z_d} !== {1'b1, ArithExp})
         $display("FAIL arith_z: got v=%b d=%0d want v=1 d=%0d", z_v, z_d, ArithExp);
      else n_pass++;
      x_v = 1'b0; y_v = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b1) $display("FAIL arith_done: got %b want 1", done);
      else n_pass++;
      tick();
   endtask

   task automatic test_backpressure();
      start_op(16'd3, 8'd2);
      x_v = 1'b1; y_v = 1'b1; x_d = 8'd1; y_d = 8'd1; z_r = 1'b0;
      #1;
      n_checks++;
      if (x_r !== 1'b1) $display("FAIL bp_first_fire: got %b want 1", x_r);
      else n_pass++;
      tick();
      x_d = 8'd2;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if ({x_r, y_r, z_v, z_d} !== {2'b00, 1'b1, 8'd3})
            $display("FAIL bp_hold%0d: got r=%b v=%b d=%0d want r=00 v=1 d=3",
                     i, {x_r, y_r}, z_v, z_d);
         else n_pass++;
         tick();
      end
      z_r = 1'b1;
      #1;
      n_checks++;
      if ({x_r, y_r} !== 2'b11) $display("FAIL bp_resume: got %b want 11", {x_r, y_r});
      else n_pass++;
      tick();
      n_checks++;
      if ({z_v, z_d} !== {1'b1, 8'd5}) $display("FAIL bp_z1: got v=%b d=%0d want v=1 d=5", z_v, z_d);
      else n_pass++;
      x_d = 8'd3;
      tick();
      n_checks++;
      if ({z_v, z_d} !== {1'b1, 8'd7}) $display("FAIL bp_z2: got v=%b d=%0d want v=1 d=7", z_v, z_d);
      else n_pass++;
      x_v = 1'b0; y_v = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done);
      else n_pass++;
      tick();
   endtask

   task automatic test_no_fire();
      start_op(16'd2, 8'd1);
      x_v = 1'b1; y_v = 1'b0; x_d = 8'd4; y_d = 8'd1; z_r = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if ({x_r, y_r, z_v, dut.rem_q} !== {3'b000, 16'd2})
            $display("FAIL nofire%0d: got r=%b v=%b rem=%0d want r=00 v=0 rem=2",
                     i, {x_r, y_r}, z_v, dut.rem_q);
         else n_pass++;
         tick();
      end
      y_v = 1'b1;
      tick();
      n_checks++;
      if ({z_v, z_d, dut.rem_q} !== {1'b1, 8'd5, 16'd1})
         $display("FAIL nofire_z0: got v=%b d=%0d rem=%0d want v=1 d=5 rem=1", z_v, z_d, dut.rem_q);
      else n_pass++;
      tick();
      x_v = 1'b0; y_v = 1'b0;
      n_checks++;
      if ({z_v, z_d, busy} !== {1'b1, 8'd5, 1'b1})
         $display("FAIL nofire_z1: got v=%b d=%0d busy=%b want v=1 d=5 busy=1", z_v, z_d, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (done !== 1'b1) $display("FAIL nofire_done: got %b want 1", done);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      start_op(16'd5, 8'd1);
      x_v = 1'b1; y_v = 1'b1; y_d = 8'd0; z_r = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         x_d = 8'(i);
         tick();
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if ({busy, z_v, done, a_r, x_r, y_r} !== 6'b0)
         $display("FAIL rstmid_now: got %b want 000000", {busy, z_v, done, a_r, x_r, y_r});
      else n_pass++;
      x_v = 1'b0; y_v = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({busy, z_v, done} !== 3'b0)
         $display("FAIL rstmid_after: got %b want 000", {busy, z_v, done});
      else n_pass++;
      start_op(16'd1, 8'd7);
      x_v = 1'b1; y_v = 1'b1; x_d = 8'd2; y_d = 8'd1;
      tick();
      n_checks++;
      if ({z_v, z_d} !== {1'b1, 8'd15})
         $display("FAIL rstmid_z: got v=%b d=%0d want v=1 d=15", z_v, z_d);
      else n_pass++;
      x_v = 1'b0; y_v = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b1) $display("FAIL rstmid_done: got %b want 1", done);
      else n_pass++;
      tick();
      n_checks++;
      if ({done, busy} !== 2'b00) $display("FAIL rstmid_idle: got %b want 00", {done, busy});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len0();
      test_arith();
      test_backpressure();
      test_no_fire();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vadd_seq_ctrl.md
VADD_SEQ_CTRL -- requirements
Module: vadd_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of vector-length counter.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a vector operation.
REQ-005 SHALL have port len  input  LEN_W  element count, sampled when start is accepted.
REQ-006 SHALL have ports a_d/a_v/a_r  input 8 / input 1 / output 1  scalar stream: data, valid, ready.
REQ-007 SHALL have ports x_d/x_v/x_r and y_d/y_v/y_r  input 8 / input 1 / output 1 each  vector operand streams.
REQ-008 SHALL have ports z_d/z_v/z_r  output 8 / output 1 / input 1  result stream.
REQ-009 SHALL have port busy  output 1  high in any state other than IDLE.
REQ-010 SHALL have port done  output 1  one-cycle pulse when the last result is accepted.

Function
REQ-011 SHALL implement states IDLE, LOAD_A, STREAM, DRAIN, FINISH.
REQ-012 SHALL accept start only in IDLE; in that case len is captured into remaining count rem.
REQ-013 SHALL, in IDLE on start with len==0, go to FINISH, consume no tokens, and pulse done next cycle.
REQ-014 SHALL, in IDLE on start with len!=0, go to LOAD_A.
REQ-015 SHALL drive a_r high only in LOAD_A; on a_v&&a_r, latch a_d into a_q and go to STREAM.
REQ-016 SHALL, in STREAM, drive x_r = y_r = x_v && y_v && (!z_v || z_r); x and y are consumed only together.
REQ-017 SHALL, on a fire (x_r high), load z_d with (a_q*x_d + y_d) mod 256 (unsigned) and set z_v the next cycle; latency is 1 cycle.
REQ-018 SHALL decrement rem on each fire; the fire with rem==1 moves STREAM to DRAIN.
REQ-019 SHALL hold z_d and z_v stable while z_v && !z_r; z_v clears on z_r unless a new fire occurs in the same cycle.
REQ-020 SHALL, in DRAIN, go to FINISH when z_v && z_r.
REQ-021 SHALL assert done for exactly one cycle in FINISH, then return to IDLE.
REQ-022 SHALL ignore start while busy; len changes while busy have no effect.
REQ-023 SHALL keep a_r, x_r, y_r low in IDLE, DRAIN, FINISH.
REQ-024 SHALL sustain one result per cycle when all streams are valid and z_r is held high.

Reset
REQ-025 SHALL, on reset low, immediately force state IDLE, rem=0, a_q=0, z_d=0, z_v=0, done=0, busy=0, all ready outputs 0.
REQ-026 SHALL abandon an in-flight vector on reset mid-operation; the pending z is discarded and no done pulse is produced.

Configuration
REQ-027 SHALL, when VADD_CTRL_SAT_EN is defined, compute z_d as min(a_q*x_d + y_d, 255) (unsigned saturation).
REQ-028 SHALL, when VADD_CTRL_SAT_EN is undefined, compute z_d as the low 8 bits of a_q*x_d + y_d (wrap).

Verification
REQ-029 SHALL cover: len=4, a=3, x={1,2,3,4}, y={10,10,10,10}, z_r=1 -> z={13,16,19,22} on consecutive cycles, done one cycle after last z.
REQ-030 SHALL cover: len=0 start -> a_r/x_r/y_r never high, done pulses once, busy high for exactly 1 cycle.
REQ-031 SHALL cover: a=20, x=20, y=5 -> z=149 without macro; z=255 with VADD_CTRL_SAT_EN.
REQ-032 SHALL cover: len=3, z_r low for 5 cycles after first z -> z_d/z_v held, x_r/y_r low, all 3 results delivered in order.
REQ-033 SHALL cover: x_v high while y_v low -> no fire, rem unchanged, x_r low.
REQ-034 SHALL cover: reset asserted in STREAM after 2 of 5 fires -> IDLE, z_v=0; a new start with len=1 completes normally.
